// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the MIPS memory responder.
package mem_resp_pkg;

  // Data-access sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the wait-state counter (supports 0..15 wait states).
  localparam int WAIT_W = 4;

  // Byte address to word index shift (32-bit words).
  localparam int WORD_OFS = 2;

  // True when a byte address is not word aligned.
  function automatic logic is_misaligned(input logic [31:0] byte_addr);
    return byte_addr[WORD_OFS-1:0] != '0;
  endfunction

endpackage

// File: rtl/word_ram.sv
// Word-wide memory with one asynchronous read port and one synchronous
// write port. Contents are never reset.
module word_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // Write port: one word per rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the single-cycle MIPS core: serves fetches from
// imem, data accesses from dmem with programmable wait states, and paces the
// core through pc_enable. A loader port fills imem while the core is held.
//
// Loader handshake: a word transfers on a rising edge where load_valid and
// load_ready are both high; load_ready is high only in IDLE with load_en set
// and rst low, and load_valid may be held to stream one word per cycle.
module mips_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_addr,
  output logic [31:0]       instr,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_in,
  input  logic              mem_read_ctrlsig,
  input  logic              mem_write_ctrlsig,
  output logic [31:0]       data_out,
  output logic              pc_enable,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              load_ready,
  output logic              align_err,
  output state_t            dbg_state
);

  localparam int HI_BIT = ADDR_W + WORD_OFS;
  localparam logic [WAIT_W-1:0] WAIT_CNT = WAIT_W'(WAIT_STATES);

  // Sequencer state and wait counter.
  state_t            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;

  // Access captured at acceptance.
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic              store_q;
  logic              misalign_q;

  // Values used at the commit edge; with zero wait states the commit
  // happens on the acceptance edge, so the live inputs are used there.
  logic [ADDR_W-1:0] in_idx;
  logic [ADDR_W-1:0] c_idx;
  logic [31:0]       c_wdata;
  logic              c_store;
  logic              c_misalign;

  logic              req;
  logic              accept;
  logic              commit;
  logic              dmem_we;
  logic              imem_we;
  logic [31:0]       dmem_rdata;
  logic [31:0]       data_out_q;
  logic              align_err_q;

  // Address bits that only alias or select bytes within a word.
  logic              unused_bits;
  assign unused_bits = ^{inst_addr[31:HI_BIT], inst_addr[WORD_OFS-1:0],
                         data_addr[31:HI_BIT]};

  assign req    = mem_read_ctrlsig | mem_write_ctrlsig;
  assign in_idx = data_addr[HI_BIT-1:WORD_OFS];

  // Next-state and counter logic for the data-access sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !load_en) begin
          accept  = 1'b1;
          cnt_d   = WAIT_CNT;
          state_d = (WAIT_STATES == 0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == WAIT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // A request still present here belongs to the finished instruction.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Select live or captured access fields for the commit edge.
  always_comb begin
    if (state_q == IDLE) begin
      c_idx      = in_idx;
      c_wdata    = data_in;
      c_store    = mem_write_ctrlsig;
      c_misalign = is_misaligned(data_addr);
    end else begin
      c_idx      = idx_q;
      c_wdata    = wdata_q;
      c_store    = store_q;
      c_misalign = misalign_q;
    end
  end

  assign commit  = (state_d == DONE) && (state_q != DONE) && !rst;
  assign dmem_we = commit && c_store && !c_misalign;

  // Core pacing: stall as soon as a request appears, release in DONE.
  always_comb begin
    pc_enable = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    pc_enable = !req && !load_en;
        BUSY:    pc_enable = 1'b0;
        DONE:    pc_enable = 1'b1;
        default: pc_enable = 1'b0;
      endcase
    end
  end

  assign load_ready = load_en && (state_q == IDLE) && !rst;
  assign imem_we    = load_valid && load_ready;

  // Sequencer state register and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the access fields when a request is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      wdata_q    <= '0;
      store_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else if (accept) begin
      idx_q      <= in_idx;
      wdata_q    <= data_in;
      store_q    <= mem_write_ctrlsig;
      misalign_q <= is_misaligned(data_addr);
    end
  end

  // Load data register and sticky misalignment flag, updated at commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q  <= '0;
      align_err_q <= 1'b0;
    end else if (commit) begin
      if (c_misalign) begin
        data_out_q  <= '0;
        align_err_q <= 1'b1;
      end else if (!c_store) begin
        data_out_q <= dmem_rdata;
      end
    end
  end

  assign data_out  = data_out_q;
  assign align_err = align_err_q;
  assign dbg_state = state_q;

  word_ram #(.ADDR_W(ADDR_W)) u_imem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (inst_addr[HI_BIT-1:WORD_OFS]),
    .rdata (instr)
  );

  word_ram #(.ADDR_W(ADDR_W)) u_dmem (
    .clk   (clk),
    .we    (dmem_we),
    .waddr (c_idx),
    .wdata (c_wdata),
    .raddr (c_idx),
    .rdata (dmem_rdata)
  );

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: a WAIT_STATES=2 instance for most
// scenarios and a WAIT_STATES=0 instance for the zero-wait path.
module tb_mips_mem_responder;
  import mem_resp_pkg::*;

  localparam int ADDR_W = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WAIT_STATES=2 instance signals
  logic [31:0]       inst_addr, instr, data_addr, data_in, data_out;
  logic              mem_read, mem_write, pc_enable;
  logic              load_en, load_valid, load_ready, align_err;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  state_t            dbg_state;

  // WAIT_STATES=0 instance signals
  logic [31:0]       z_inst_addr, z_instr, z_data_addr, z_data_in, z_data_out;
  logic              z_mem_read, z_mem_write, z_pc_enable;
  logic              z_load_en, z_load_valid, z_load_ready, z_align_err;
  logic [ADDR_W-1:0] z_load_addr;
  logic [31:0]       z_load_data;
  state_t            z_dbg_state;

  mips_mem_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(2)) u_dut (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .instr(instr),
    .data_addr(data_addr), .data_in(data_in),
    .mem_read_ctrlsig(mem_read), .mem_write_ctrlsig(mem_write),
    .data_out(data_out), .pc_enable(pc_enable),
    .load_en(load_en), .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .load_ready(load_ready),
    .align_err(align_err), .dbg_state(dbg_state)
  );

  mips_mem_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .inst_addr(z_inst_addr), .instr(z_instr),
    .data_addr(z_data_addr), .data_in(z_data_in),
    .mem_read_ctrlsig(z_mem_read), .mem_write_ctrlsig(z_mem_write),
    .data_out(z_data_out), .pc_enable(z_pc_enable),
    .load_en(z_load_en), .load_valid(z_load_valid), .load_addr(z_load_addr),
    .load_data(z_load_data), .load_ready(z_load_ready),
    .align_err(z_align_err), .dbg_state(z_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] dmem_m [2**ADDR_W];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Runs one data access on the WAIT_STATES=2 instance. Returns the number
  // of stalled cycles and data_out sampled in the first cycle pc_enable
  // rises (the DONE cycle).
  task automatic mem_op(input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lows, output logic [31:0] dout);
    @(negedge clk);
    data_addr = addr;
    data_in   = wdata;
    mem_read  = rd;
    mem_write = wr;
    #1;
    lows = 0;
    while (!pc_enable && lows < 40) begin
      lows++;
      @(negedge clk);
      #1;
    end
    dout = data_out;
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr,
                          input logic [31:0] wdata);
    int          lows;
    logic [31:0] dout;
    mem_op(1'b0, 1'b1, addr, wdata, lows, dout);
    check({tag, "_stall"}, lows, 3);
    if (addr[1:0] == 2'b00) dmem_m[addr[11:2]] = wdata;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr);
    int          lows;
    logic [31:0] dout;
    exp_q.push_back(addr[1:0] != 2'b00 ? 32'h0 : dmem_m[addr[11:2]]);
    mem_op(1'b1, 1'b0, addr, 32'h0, lows, dout);
    check({tag, "_stall"}, lows, 3);
    check({tag, "_data"}, dout, exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lows;
    logic [31:0] dout;

    rst = 1'b1;
    inst_addr = '0; data_addr = '0; data_in = '0;
    mem_read = 1'b0; mem_write = 1'b0;
    load_en = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0;
    z_inst_addr = '0; z_data_addr = '0; z_data_in = '0;
    z_mem_read = 1'b0; z_mem_write = 1'b0;
    z_load_en = 1'b0; z_load_valid = 1'b0; z_load_addr = '0; z_load_data = '0;

    // Reset state
    #12;
    check("rst_pc_enable", pc_enable, 0);
    check("rst_data_out", data_out, 0);
    check("rst_align_err", align_err, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_pc_enable0", z_pc_enable, 0);

    // Loader then fetch: two words on consecutive cycles
    @(negedge clk);
    rst = 1'b0;
    load_valid = 1'b1; load_addr = 10'd3; load_data = 32'h8C01_0004;
    #1;
    check("ld_ready", load_ready, 1);
    check("ld_pc_enable_w0", pc_enable, 0);
    @(negedge clk);
    load_addr = 10'd5; load_data = 32'h2002_0005;
    #1;
    check("ld_pc_enable_w1", pc_enable, 0);
    @(negedge clk);
    load_en = 1'b0; load_valid = 1'b0;
    inst_addr = 32'h0000_000C;
    #1;
    check("fetch_w3", instr, 32'h8C01_0004);
    check("fetch_pc_enable", pc_enable, 1);
    inst_addr = 32'h0000_0014;
    #1;
    check("fetch_w5", instr, 32'h2002_0005);
    inst_addr = 32'h0000_100F;
    #1;
    check("fetch_alias", instr, 32'h8C01_0004);

    // Non-memory instructions: no stall
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("nomem_pc_enable", pc_enable, 1);
    end

    // Store then load, WAIT_STATES=2
    do_store("st10", 32'h10, 32'hDEAD_BEEF);
    check("st10_data_out_kept", data_out, 0);
    #1;
    check("after_st_pc_enable", pc_enable, 1);
    do_load("ld10", 32'h10);

    // Address wrap
    do_store("st_wrap", 32'h1004, 32'h0000_0055);
    do_load("ld_wrap", 32'h0004);

    // Read and write both high: store wins, data_out unchanged
    mem_op(1'b1, 1'b1, 32'h20, 32'h0000_A5A5, lows, dout);
    check("both_stall", lows, 3);
    check("both_data_out_kept", dout, 32'h0000_0055);
    dmem_m[32'h20 >> 2] = 32'h0000_A5A5;
    do_load("ld20", 32'h20);

    // Async reset mid-BUSY aborts the store
    do_store("st40", 32'h40, 32'h1111_1111);
    do_load("ld40a", 32'h40);
    @(negedge clk);
    data_addr = 32'h40; data_in = 32'h2222_2222; mem_write = 1'b1;
    @(negedge clk);
    #1;
    check("midbusy_state", 32'(dbg_state), 32'(BUSY));
    #1;
    rst = 1'b1;
    #1;
    check("rstbusy_state", 32'(dbg_state), 32'(IDLE));
    check("rstbusy_pc_enable", pc_enable, 0);
    check("rstbusy_data_out", data_out, 0);
    @(negedge clk);
    mem_write = 1'b0;
    rst = 1'b0;
    do_load("ld40b", 32'h40);

    // Misaligned store: no write, data_out cleared, sticky flag
    do_load("ld10_pre", 32'h10);
    check("pre_mis_align_err", align_err, 0);
    mem_op(1'b0, 1'b1, 32'h13, 32'h1234_5678, lows, dout);
    check("mis_stall", lows, 3);
    check("mis_data_out", dout, 0);
    check("mis_align_err", align_err, 1);
    do_load("ld10_post", 32'h10);
    check("mis_align_sticky", align_err, 1);

    // load_en raised in IDLE blocks acceptance
    @(negedge clk);
    load_en = 1'b1;
    data_addr = 32'h10; mem_read = 1'b1;
    #1;
    check("blk_pc_enable", pc_enable, 0);
    @(negedge clk);
    #1;
    check("blk_state", 32'(dbg_state), 32'(IDLE));
    load_en = 1'b0; mem_read = 1'b0;

    // WAIT_STATES=0: store then load, one stall cycle each
    @(negedge clk);
    z_data_addr = 32'h8; z_data_in = 32'hCAFE_F00D; z_mem_write = 1'b1;
    #1;
    check("z_st_c0_pc_enable", z_pc_enable, 0);
    @(negedge clk);
    #1;
    check("z_st_c1_pc_enable", z_pc_enable, 1);
    @(negedge clk);
    z_mem_write = 1'b0;
    z_mem_read = 1'b1;
    #1;
    check("z_ld_c0_pc_enable", z_pc_enable, 0);
    @(negedge clk);
    #1;
    check("z_ld_c1_pc_enable", z_pc_enable, 1);
    check("z_ld_data", z_data_out, 32'hCAFE_F00D);
    @(negedge clk);
    z_mem_read = 1'b0;
    #1;
    check("z_idle_pc_enable", z_pc_enable, 1);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got=%0d expected=%0d", 0, 1);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_mem_responder.md
# mips_mem_responder

Memory-side responder for the single-cycle MIPS processor: it serves the core's instruction-fetch and data-access requests from a local instruction memory and data memory. Data accesses incur a programmable number of wait states, and the block paces the core through `pc_enable` while an access is in flight. A side-band loader port fills instruction memory while the core is held.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width of each memory (2^ADDR_W 32-bit words).
- `WAIT_STATES`, 2: extra cycles per data access, range 0..15.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inst_addr`  in  32  byte address of the fetch.
- `instr`  out  32  fetched instruction word.
- `data_addr`  in  32  byte address of the data access.
- `data_in`  in  32  store data from the core.
- `mem_read_ctrlsig`  in  1  load request (level, held for the whole instruction).
- `mem_write_ctrlsig`  in  1  store request (level).
- `data_out`  out  32  load data returned to the core.
- `pc_enable`  out  1  PC advance permit; 0 stalls the core.
- `load_en`  in  1  loader mode; holds the core.
- `load_valid`  in  1  loader word valid.
- `load_addr`  in  ADDR_W  loader word address.
- `load_data`  in  32  loader word.
- `load_ready`  out  1  loader word accepted when high with `load_valid`.
- `align_err`  out  1  sticky misaligned-data-access flag.

## Operation
- **Fetch**
  - `instr` = imem[`inst_addr[ADDR_W+1:2]`], combinational.
  - Low two bits are ignored; upper bits alias (wrap-around).
- **Request**
  - `req` = `mem_read_ctrlsig | mem_write_ctrlsig`.
  - If both are high, the access is a store; `data_out` is unchanged.
- **FSM states:** IDLE, BUSY, DONE.
  - IDLE, with `req` and not `load_en`: accept the access.
    - Latch the word index `data_addr[ADDR_W+1:2]`, `data_in`, the op, and misalignment (`data_addr[1:0]` != 0).
    - Load counter with `WAIT_STATES`.
    - Go to BUSY, or to DONE if `WAIT_STATES`=0.
  - BUSY: decrement counter each cycle. When the counter reads 1, go to DONE.
  - DONE: go to IDLE unconditionally. The request still present in DONE belongs to the same instruction and is ignored.
- **Commit:** on the edge entering DONE.
  - Store: write the latched data into dmem.
  - Load: register dmem[latched index] into `data_out`.
  - Misaligned access: no write, `data_out` <= 0, `align_err` <= 1. `align_err` stays set until `rst`.
- **`pc_enable`**
  - IDLE: `!req && !load_en`, combinational, so the core stalls in the same cycle the request appears.
  - BUSY: 0.
  - DONE: 1, regardless of `load_en`.
- **Loader**
  - `load_ready` = `load_en` && state==IDLE.
  - On `load_valid && load_ready`: imem[`load_addr`] <= `load_data`.
  - `load_en` raised mid-access: the access completes first. `load_ready` stays low until IDLE.
  - In IDLE, `load_en` blocks new acceptance.
- **Reset (async)**
  - state=IDLE, counter=0, `data_out`=0, `align_err`=0, `load_ready`=0.
  - `pc_enable`=0 while `rst` is high.
  - Memory contents are not cleared.
  - Reset mid-access aborts it: no dmem write occurs unless the DONE-entry edge has already passed.

## Timing
- Data access occupies `WAIT_STATES`+2 cycles from first request cycle C0 through DONE.
  - `pc_enable`=0 for `WAIT_STATES`+1 cycles.
  - `data_out` is valid from the DONE cycle until the next load commit.
- Non-memory instructions: `pc_enable`=1 in every cycle; zero added latency.
- Loader: one word per cycle while `load_valid` is held high in IDLE.
- Back-to-back memory instructions: DONE → IDLE, then the next request is accepted in that IDLE cycle.

## Structure
- Package `mem_resp_pkg`:
  - state enum (IDLE, BUSY, DONE);
  - `WAIT_W`=4 counter width;
  - `WORD_OFS`=2 byte-to-word shift.
- Sub-module `word_ram`:
  - one async read port, one sync write port;
  - parameter `ADDR_W`;
  - instantiated twice: imem (loader writes) and dmem (data path).
  - dmem read is registered in the parent.

## Test plan
- **Loader then fetch.** `load_en`=1, write 0x8C010004 to word 3, release. `inst_addr`=0x0C → `instr`=0x8C010004; `pc_enable` was 0 throughout loading.
- **Store then load, `WAIT_STATES`=2.**
  - Store: `data_addr`=0x10, `data_in`=0xDEADBEEF, write held → `pc_enable` low for 3 cycles, high in cycle 4.
  - Load from 0x10 → `data_out`=0xDEADBEEF in its DONE cycle.
- **`WAIT_STATES`=0.** Load request → `pc_enable` low for exactly 1 cycle, data in cycle 2.
- **Misaligned access.** Store to 0x13 → dmem word 4 unchanged, `align_err`=1 sticky. A subsequent aligned load works; `align_err` stays 1.
- **Address wrap.** `ADDR_W`=10, store 0x55 to 0x1004 → load from 0x0004 returns 0x55.
- **Async reset mid-BUSY.** Assert `rst` during BUSY → immediately state=IDLE, `pc_enable`=0, `data_out`=0; the target dmem word is unchanged.
